// File: rtl/jb_rf_odp_ctrl.sv
// RF overdrive protection: windowed per-channel power sums with a per-channel
// trip / mute / holdoff state machine sharing one window beat counter.
`default_nettype none

module jb_rf_odp_ctrl #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned PWR_W       = 16,
  parameter int unsigned HOLDOFF_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pwr_valid,
  input  logic [NUM_CH*PWR_W-1:0]  pwr_data,
  input  logic [31:0]              rf_overdrive_thresh,
  input  logic [20:0]              rf_overdrive_avg_per,
  input  logic [NUM_CH-1:0]        disable_rf_odp,
  input  logic [NUM_CH-1:0]        clr_trip,
  output logic [NUM_CH*32-1:0]     rf_overdrive_tssi,
  output logic                     window_done,
  output logic [NUM_CH-1:0]        odp_trip,
  output logic [NUM_CH-1:0]        pa_mute
);

  localparam int unsigned CNT_W     = 21;
  localparam int unsigned SUM_W     = 32;
  localparam int unsigned EXT_W     = SUM_W + 1;
  localparam int unsigned HOLD_LAST = (HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0;
  localparam int unsigned HCNT_W    = (HOLD_LAST > 0) ? $clog2(HOLD_LAST + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    TRIPPED = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] per_last;
  logic             close_c;

  // A zero period behaves as one; ">=" lets a lowered period close on the next beat.
  assign per_last = (rf_overdrive_avg_per == '0) ? '0 : rf_overdrive_avg_per - CNT_W'(1);
  assign close_c  = pwr_valid && (beat_cnt >= per_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt    <= '0;
      window_done <= 1'b0;
    end else begin
      window_done <= close_c;
      if (pwr_valid) begin
        beat_cnt <= close_c ? '0 : beat_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [PWR_W-1:0]  sample;
    logic [EXT_W-1:0]  raw_sum;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  acc;
    logic [SUM_W-1:0]  tssi_q;
    logic              trip_c;
    state_t            state, state_nxt;
    logic [HCNT_W-1:0] hcnt, hcnt_nxt;
    logic              trip_q, mute_q;

    assign sample  = pwr_data[ch*PWR_W +: PWR_W];
    assign raw_sum = {1'b0, acc} + EXT_W'(sample);
    assign sum     = raw_sum[SUM_W] ? {SUM_W{1'b1}} : raw_sum[SUM_W-1:0];
    assign trip_c  = close_c && (sum > rf_overdrive_thresh) && (state == ARMED);

    // Accumulation and tssi capture run regardless of FSM state.
    always_ff @(posedge clk) begin
      if (rst) begin
        acc    <= '0;
        tssi_q <= '0;
      end else if (pwr_valid) begin
        if (close_c) begin
          acc    <= '0;
          tssi_q <= sum;
        end else begin
          acc <= sum;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= IDLE;
        hcnt   <= '0;
        trip_q <= 1'b0;
        mute_q <= 1'b0;
      end else begin
        state  <= state_nxt;
        hcnt   <= hcnt_nxt;
        trip_q <= (state_nxt == TRIPPED);
        mute_q <= (state_nxt == TRIPPED) || (state_nxt == HOLDOFF);
      end
    end

    // Disable dominates; a trip can only be detected from ARMED, so clr_trip cannot pre-empt it.
    always_comb begin
      state_nxt = state;
      hcnt_nxt  = hcnt;
      if (disable_rf_odp[ch]) begin
        state_nxt = IDLE;
        hcnt_nxt  = '0;
      end else begin
        case (state)
          IDLE:    state_nxt = ARMED;
          ARMED:   if (trip_c) state_nxt = TRIPPED;
          TRIPPED: begin
            if (clr_trip[ch]) begin
              state_nxt = HOLDOFF;
              hcnt_nxt  = '0;
            end
          end
          HOLDOFF: begin
            if (hcnt == HCNT_W'(HOLD_LAST)) begin
              state_nxt = ARMED;
              hcnt_nxt  = '0;
            end else begin
              hcnt_nxt = hcnt + HCNT_W'(1);
            end
          end
          default: begin
            state_nxt = IDLE;
            hcnt_nxt  = '0;
          end
        endcase
      end
    end

    assign rf_overdrive_tssi[ch*32 +: 32] = tssi_q;
    assign odp_trip[ch]                   = trip_q;
    assign pa_mute[ch]                    = mute_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_jb_rf_odp_ctrl.sv
// Directed bench for jb_rf_odp_ctrl; 32-bit samples so saturation is reachable in a few beats.
`timescale 1ns/1ps

module tb_jb_rf_odp_ctrl;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned PWR_W  = 32;
  localparam int unsigned HOLD   = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    pwr_valid;
  logic [NUM_CH*PWR_W-1:0] pwr_data;
  logic [31:0]             rf_overdrive_thresh;
  logic [20:0]             rf_overdrive_avg_per;
  logic [NUM_CH-1:0]       disable_rf_odp;
  logic [NUM_CH-1:0]       clr_trip;
  logic [NUM_CH*32-1:0]    rf_overdrive_tssi;
  logic                    window_done;
  logic [NUM_CH-1:0]       odp_trip;
  logic [NUM_CH-1:0]       pa_mute;

  int checks = 0;
  int errors = 0;

  jb_rf_odp_ctrl #(.NUM_CH(NUM_CH), .PWR_W(PWR_W), .HOLDOFF_CYC(HOLD)) dut (
    .clk(clk), .rst(rst), .pwr_valid(pwr_valid), .pwr_data(pwr_data),
    .rf_overdrive_thresh(rf_overdrive_thresh), .rf_overdrive_avg_per(rf_overdrive_avg_per),
    .disable_rf_odp(disable_rf_odp), .clr_trip(clr_trip),
    .rf_overdrive_tssi(rf_overdrive_tssi), .window_done(window_done),
    .odp_trip(odp_trip), .pa_mute(pa_mute)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [31:0] d0, d1, d2, d3);
    pwr_data = {d3, d2, d1, d0};
  endtask

  function automatic logic [31:0] tssi(input int ch);
    return rf_overdrive_tssi[ch*32 +: 32];
  endfunction

  task automatic rearm();
    disable_rf_odp = '1;
    cyc();
    disable_rf_odp = '0;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; pwr_valid = 1'b0; set_data(0, 0, 0, 0);
    rf_overdrive_thresh = 32'd1000; rf_overdrive_avg_per = 21'd4;
    disable_rf_odp = '0; clr_trip = '0;
    cyc(); cyc();
    checks++;
    if (rf_overdrive_tssi !== '0 || window_done !== 1'b0 || odp_trip !== 4'h0 || pa_mute !== 4'h0) begin
      errors++;
      $display("FAIL reset: tssi=%h wd=%b trip=%b mute=%b, required all zero",
               rf_overdrive_tssi, window_done, odp_trip, pa_mute);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic_window();
    set_data(300, 300, 300, 300);
    pwr_valid = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      cyc();
      checks++;
      if (window_done !== 1'b0) begin
        errors++;
        $display("FAIL basic_early_wd beat %0d: got %b required 0", b, window_done);
      end
    end
    cyc();
    checks++;
    if (window_done !== 1'b1 || odp_trip !== 4'hF || pa_mute !== 4'hF) begin
      errors++;
      $display("FAIL basic_first_window: wd=%b trip=%b mute=%b required 1 1111 1111",
               window_done, odp_trip, pa_mute);
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      checks++;
      if (tssi(ch) !== 32'd1200) begin
        errors++;
        $display("FAIL basic_tssi ch%0d: got %0d required 1200", ch, tssi(ch));
      end
    end
    for (int b = 1; b <= 4; b++) cyc();
    checks++;
    if (window_done !== 1'b1 || tssi(3) !== 32'd1200) begin
      errors++;
      $display("FAIL basic_second_window: wd=%b tssi3=%0d required 1 1200", window_done, tssi(3));
    end
    pwr_valid = 1'b0;
  endtask

  task automatic test_holdoff();
    clr_trip = 4'b0001;
    cyc();
    clr_trip = '0;
    checks++;
    if (odp_trip !== 4'b1110 || pa_mute !== 4'hF) begin
      errors++;
      $display("FAIL holdoff_clear: trip=%b mute=%b required 1110 1111", odp_trip, pa_mute);
    end
    for (int k = 1; k < HOLD; k++) cyc();
    checks++;
    if (pa_mute[0] !== 1'b1) begin
      errors++;
      $display("FAIL holdoff_last_cycle: mute0=%b required 1", pa_mute[0]);
    end
    cyc();
    checks++;
    if (pa_mute[0] !== 1'b0 || odp_trip[0] !== 1'b0) begin
      errors++;
      $display("FAIL holdoff_release: mute0=%b trip0=%b required 0 0", pa_mute[0], odp_trip[0]);
    end
    // Back in ARMED: a fresh over-threshold window must trip ch0 again.
    pwr_valid = 1'b1;
    for (int b = 0; b < 4; b++) cyc();
    pwr_valid = 1'b0;
    checks++;
    if (window_done !== 1'b1 || odp_trip !== 4'hF) begin
      errors++;
      $display("FAIL holdoff_rearmed: wd=%b trip=%b required 1 1111", window_done, odp_trip);
    end
  endtask

  task automatic test_saturation();
    rearm();
    checks++;
    if (odp_trip !== 4'h0 || pa_mute !== 4'h0) begin
      errors++;
      $display("FAIL disable_all: trip=%b mute=%b required 0000 0000", odp_trip, pa_mute);
    end
    rf_overdrive_thresh = 32'hFFFF_FFFF;
    rf_overdrive_avg_per = 21'd0;
    set_data(32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF);
    pwr_valid = 1'b1;
    cyc(); cyc();
    checks++;
    if (window_done !== 1'b1 || tssi(0) !== 32'h0000_FFFF || tssi(2) !== 32'h0000_FFFF || odp_trip !== 4'h0) begin
      errors++;
      $display("FAIL per0_window: wd=%b tssi0=%h tssi2=%h trip=%b required 1 0000ffff 0000ffff 0000",
               window_done, tssi(0), tssi(2), odp_trip);
    end
    rf_overdrive_avg_per = 21'h1F_FFFF;
    set_data(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc(); cyc(); cyc();
    checks++;
    if (window_done !== 1'b0) begin
      errors++;
      $display("FAIL long_window_open: wd=%b required 0", window_done);
    end
    // Lowering the period below the count closes on the very next beat.
    rf_overdrive_avg_per = 21'd2;
    cyc();
    pwr_valid = 1'b0;
    checks++;
    if (window_done !== 1'b1 || tssi(1) !== 32'hFFFF_FFFF || odp_trip !== 4'h0 || pa_mute !== 4'h0) begin
      errors++;
      $display("FAIL saturate: wd=%b tssi1=%h trip=%b mute=%b required 1 ffffffff 0000 0000",
               window_done, tssi(1), odp_trip, pa_mute);
    end
  endtask

  task automatic test_thresh_edge();
    rearm();
    rf_overdrive_thresh = 32'd1000;
    rf_overdrive_avg_per = 21'd2;
    pwr_valid = 1'b1;
    set_data(500, 500, 500, 0);
    cyc();
    set_data(500, 501, 501, 0);
    clr_trip = 4'b0100;
    cyc();
    clr_trip = '0;
    pwr_valid = 1'b0;
    checks++;
    if (window_done !== 1'b1 || tssi(0) !== 32'd1000 || tssi(1) !== 32'd1001 || tssi(3) !== 32'd0) begin
      errors++;
      $display("FAIL thresh_tssi: wd=%b t0=%0d t1=%0d t3=%0d required 1 1000 1001 0",
               window_done, tssi(0), tssi(1), tssi(3));
    end
    checks++;
    if (odp_trip !== 4'b0110 || pa_mute !== 4'b0110) begin
      errors++;
      $display("FAIL thresh_trip: trip=%b mute=%b required 0110 0110", odp_trip, pa_mute);
    end
    cyc();
    checks++;
    if (odp_trip !== 4'b0110) begin
      errors++;
      $display("FAIL trip_beats_clr: trip=%b required 0110", odp_trip);
    end
  endtask

  task automatic test_disable();
    disable_rf_odp = 4'b0100;
    cyc();
    checks++;
    if (odp_trip !== 4'b0010 || pa_mute !== 4'b0010) begin
      errors++;
      $display("FAIL disable_ch2: trip=%b mute=%b required 0010 0010", odp_trip, pa_mute);
    end
    set_data(0, 0, 7, 0);
    pwr_valid = 1'b1;
    cyc(); cyc();
    pwr_valid = 1'b0;
    checks++;
    if (window_done !== 1'b1 || tssi(2) !== 32'd14 || odp_trip !== 4'b0010 || pa_mute !== 4'b0010) begin
      errors++;
      $display("FAIL disable_tssi: wd=%b tssi2=%0d trip=%b mute=%b required 1 14 0010 0010",
               window_done, tssi(2), odp_trip, pa_mute);
    end
    disable_rf_odp = '0;
  endtask

  task automatic test_reset_mid_window();
    rearm();
    rf_overdrive_avg_per = 21'd4;
    set_data(300, 300, 300, 300);
    pwr_valid = 1'b1;
    cyc(); cyc();
    rst = 1'b1;
    pwr_valid = 1'b0;
    cyc();
    checks++;
    if (rf_overdrive_tssi !== '0 || window_done !== 1'b0 || odp_trip !== 4'h0 || pa_mute !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid: tssi=%h wd=%b trip=%b mute=%b required all zero",
               rf_overdrive_tssi, window_done, odp_trip, pa_mute);
    end
    rst = 1'b0;
    pwr_valid = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      cyc();
      checks++;
      if (window_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_early_wd beat %0d: got %b required 0", b, window_done);
      end
    end
    cyc();
    pwr_valid = 1'b0;
    checks++;
    if (window_done !== 1'b1 || tssi(0) !== 32'd1200 || odp_trip !== 4'hF) begin
      errors++;
      $display("FAIL reset_mid_window: wd=%b tssi0=%0d trip=%b required 1 1200 1111",
               window_done, tssi(0), odp_trip);
    end
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_holdoff();
    test_saturation();
    test_thresh_edge();
    test_disable();
    test_reset_mid_window();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
